// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture/decode path: FSM states,
// segment pattern type, segment bit positions and default geometry.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURED = 2'd2
   } cap_state_t;

   // Bit 0 is the top segment, bit 6 the middle bar; all active-high.
   typedef logic [6:0] seg_t;

   localparam int SEG_TOP     = 0;
   localparam int SEG_UP_R    = 1;
   localparam int SEG_LOW_R   = 2;
   localparam int SEG_BOTTOM  = 3;
   localparam int SEG_LOW_L   = 4;
   localparam int SEG_UP_L    = 5;
   localparam int SEG_MID     = 6;

   localparam int SEG7_NDIG_DEF       = 4;
   localparam int SEG7_STABLE_CYC_DEF = 8;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Output stream of the capture stage: one segment pattern plus digit index per
// transfer, valid/ready handshake. master = producer, slave = consumer.
interface seg7_scan_capture_if #(
   parameter int IDX_W = 2
);
   import seg7_pkg::*;

   seg_t             out_seg;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_seg, out_idx, out_valid, input out_ready);
   modport slave  (input out_seg, out_idx, out_valid, output out_ready);

endinterface

// File: rtl/seg7_sync2.sv
// Parameterised-width two-flop synchroniser; used by seg7_scan_capture only
// when SEG7_CAP_SYNC_EN is defined.
module seg7_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;
   logic [W-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-segment bus and emits one stable pattern per strobe window.
// Optional macro SEG7_CAP_SYNC_EN: two-flop synchronisers on seg_in/dig_sel (+2 cycles latency).
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NDIG       = SEG7_NDIG_DEF,
   parameter int STABLE_CYC = SEG7_STABLE_CYC_DEF,
   parameter int IDX_W      = $clog2(NDIG)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  seg_t                       seg_in,
   input  logic [NDIG-1:0]            dig_sel,
   seg7_scan_capture_if.master        cap,
   output logic                       frame_valid,
   output logic                       overflow
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

   seg_t             seg_d;
   logic [NDIG-1:0]  sel_d;

`ifdef SEG7_CAP_SYNC_EN
   seg7_sync2 #(.W(7)) u_sync_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (seg_in),
      .q     (seg_d)
   );
   seg7_sync2 #(.W(NDIG)) u_sync_sel (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dig_sel),
      .q     (sel_d)
   );
`else
   assign seg_d = seg_in;
   assign sel_d = dig_sel;
`endif

   seg_t             s_seg_reg;
   logic [NDIG-1:0]  s_sel_reg;
   logic [7:0]       cnt_reg;
   cap_state_t       state_reg;
   logic [NDIG-1:0]  seen_reg;
   seg_t             out_seg_reg;
   logic [IDX_W-1:0] out_idx_reg;
   logic             out_valid_reg;
   logic             frame_valid_reg;
   logic             overflow_reg;

   // Change detection compares the value being loaded against the current sample,
   // so the counter restarts in the same cycle the sample register takes a new value.
   logic             changed;
   logic             sel_onehot;
   logic             capture;
   logic [NDIG-1:0]  seen_set;
   logic [IDX_W-1:0] sel_idx;

   assign changed    = (seg_d != s_seg_reg) || (sel_d != s_sel_reg);
   assign sel_onehot = $onehot(sel_d);
   assign capture    = (state_reg == ST_SETTLE) && sel_onehot && !changed &&
                       (cnt_reg == CNT_MAX);
   assign seen_set   = seen_reg | s_sel_reg;

   for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx
      logic [NDIG-1:0] hit;
      for (genvar gj = 0; gj < NDIG; gj++) begin : g_dig
         assign hit[gj] = (((gj >> gi) & 1) != 0) ? s_sel_reg[gj] : 1'b0;
      end
      assign sel_idx[gi] = |hit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_seg_reg       <= '0;
         s_sel_reg       <= '0;
         cnt_reg         <= '0;
         state_reg       <= ST_IDLE;
         seen_reg        <= '0;
         out_seg_reg     <= '0;
         out_idx_reg     <= '0;
         out_valid_reg   <= 1'b0;
         frame_valid_reg <= 1'b0;
         overflow_reg    <= 1'b0;
      end else begin
         s_seg_reg       <= seg_d;
         s_sel_reg       <= sel_d;
         frame_valid_reg <= 1'b0;

         if (changed || !sel_onehot) begin
            cnt_reg <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 8'd1;
         end

         case (state_reg)
            ST_IDLE: begin
               if (sel_onehot) state_reg <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!sel_onehot)  state_reg <= ST_IDLE;
               else if (capture) state_reg <= ST_CAPTURED;
            end
            ST_CAPTURED: begin
               if (!sel_onehot)  state_reg <= ST_IDLE;
               else if (changed) state_reg <= ST_SETTLE;
            end
            default: state_reg <= ST_IDLE;
         endcase

         // A capture that finds the holding register full and not draining is lost.
         if (capture && (!out_valid_reg || cap.out_ready)) begin
            out_seg_reg   <= s_seg_reg;
            out_idx_reg   <= sel_idx;
            out_valid_reg <= 1'b1;
            if (seen_set == '1) begin
               seen_reg        <= '0;
               frame_valid_reg <= 1'b1;
            end else begin
               seen_reg <= seen_set;
            end
         end else begin
            if (capture) overflow_reg <= 1'b1;
            if (out_valid_reg && cap.out_ready) out_valid_reg <= 1'b0;
         end
      end
   end

   assign cap.out_seg   = out_seg_reg;
   assign cap.out_idx   = out_idx_reg;
   assign cap.out_valid = out_valid_reg;
   assign frame_valid   = frame_valid_reg;
   assign overflow      = overflow_reg;

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Upstream capture stage for the seven-segment decode path. Samples a multiplexed seven-segment display bus (shared segment lines plus one-hot digit strobes) and waits until each strobe window is stable. Emits one captured segment pattern per window, tagged with its digit index, on a valid/ready interface. The output feeds the segment-to-digit encoder directly.

## Interface
- `NDIG`, default 4: number of multiplexed digits (2..8).
- `STABLE_CYC`, default 8: consecutive identical samples required before capture (2..255).
- `IDX_W`, default 2: width of the digit index, equal to $clog2(NDIG).
- `clk` in, 1: sole clock, rising edge.
- `rst_n` in, 1: synchronous, active-low reset.
- `seg_in` in, 7: raw segment lines. Bit 0 = segment 1 (top) through bit 6 = segment 7 (middle). Active-high.
- `dig_sel` in, NDIG: digit strobes. Active-high, expected one-hot.
- `out_seg` out, 7: captured segment pattern.
- `out_idx` out, IDX_W: index of the strobe bit that was high.
- `out_valid` out, 1: holding register occupied.
- `out_ready` in, 1: consumer accepts when it is high together with `out_valid`.
- `frame_valid` out, 1: one-cycle pulse when every digit has been captured since the last pulse.
- `overflow` out, 1: sticky flag; a capture was dropped.

## Operation
- Input sample registers `s_seg` and `s_sel` load every cycle.
- A stability counter `cnt` saturates at STABLE_CYC-1. It clears to 0 in the cycle where `s_seg` or `s_sel` differs from its previous value, or where `s_sel` is not exactly one-hot.
- FSM states:
  - IDLE: `s_sel` is zero or multi-hot. Moves to SETTLE when `s_sel` is one-hot.
  - SETTLE: counting. Returns to IDLE if `s_sel` becomes non-one-hot. Stays in SETTLE with `cnt`=0 on any change. Moves to CAPTURED when `cnt` == STABLE_CYC-1 and the current sample equals the previous one.
  - CAPTURED: exactly one capture per window. Moves to SETTLE (`cnt`=0) on any change of `s_sel` or `s_seg`, or to IDLE if `s_sel` is non-one-hot.
- On the SETTLE→CAPTURED transition:
  - Load `out_seg`/`out_idx` and set `out_valid`.
  - Set seen-mask bit `out_idx`.
- Holding register (one entry):
  - A handshake (`out_valid` & `out_ready`) clears `out_valid`, unless a capture occurs in the same cycle. In that case the new data loads and `out_valid` stays high.
  - A capture while `out_valid`=1 and `out_ready`=0 is dropped. `overflow` is set, the held data is unchanged, and the seen mask is not updated.
- Frame tracking:
  - When the seen mask becomes all-ones, `frame_valid` pulses for one cycle and the mask clears.
  - The pulse coincides with `out_valid` rising for the completing digit.
- A segment change within a window (ghosting) restarts the count. A second capture in the same strobe window is only possible after the pattern changes.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - `out_seg`=0, `out_idx`=0, `out_valid`=0, `frame_valid`=0, `overflow`=0.
  - `cnt`=0, seen mask=0, sample registers=0, FSM=IDLE.
- Reset mid-capture discards held data. No `out_valid` is asserted until a full new stable window has elapsed.
- Without the macro: `out_valid` rises STABLE_CYC+1 clock edges after `seg_in`/`dig_sel` settle at the ports.
- With the macro: latency is STABLE_CYC+3.
- `out_ready` is not registered. Throughput is one capture per cycle at most. Captures are limited in practice by the window length.

## Configuration
- `SEG7_CAP_SYNC_EN` defined:
  - `seg_in` and `dig_sel` pass through two-flop synchronisers before the sample registers. This adds 2 cycles of latency.
  - Required when the display driver is off-chip and asynchronous.
- Undefined: the ports feed the sample registers directly. The inputs are then assumed synchronous to `clk`.

## Structure
- Shared package `seg7_pkg`:
  - FSM state enum (IDLE, SETTLE, CAPTURED).
  - 7-bit segment pattern typedef and segment bit-position constants.
  - Default NDIG/STABLE_CYC constants, which the encoder also uses.
- One sub-module, `seg7_sync2`: parameterised-width two-flop synchroniser, instantiated only under `SEG7_CAP_SYNC_EN`.
- FSM, counter, holding register and seen mask live in the top module.

## Test plan
- Capture: hold `dig_sel`=4'b0010, `seg_in`=7'b0000110 for 12 cycles, `out_ready`=1.
  - Expect exactly one `out_valid` pulse at STABLE_CYC+1 with `out_seg`=7'b0000110, `out_idx`=1.
- Glitch: `seg_in`=7'b1011011 for 5 cycles, then 7'b1001111 for 10 cycles, strobe 4'b0001.
  - Expect a single capture of 7'b1001111 only.
- Frame: scan digits 0..3 with patterns 0/1/2/3 (7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111), 10 cycles each.
  - Expect four captures, and `frame_valid` asserted once, together with the idx-3 capture.
- Backpressure: `out_ready`=0 across two windows.
  - Expect first data held, second dropped, `overflow`=1 and sticky.
  - Then raise `out_ready`: one handshake, `out_valid`=0.
- Simultaneous: a capture completes in the same cycle as a handshake of older data.
  - Expect new data loaded, `out_valid` stays 1, `overflow`=0.
- Invalid strobes and reset:
  - `dig_sel`=4'b0110 for 20 cycles: no capture.
  - Assert `rst_n`=0 at cycle 5 of a valid window: all outputs 0. After release, capture requires a full STABLE_CYC window.
